count_bcd_display: RTL and testbench
====================================

// Module: count_bcd_display
// PURPOSE
//  Downstream consumer of the 8-bit counter value y. Accepts an 8-bit binary
//  sample via a valid/ready handshake and converts it to 3-digit BCD with an
//  iterative shift-add-3 (double-dabble) engine. It holds the result and
//  time-multiplexes it onto a 3-digit 7-segment display.
// PARAMETERS
//  SCAN_DIV  4  clock cycles each digit stays enabled (>=1)
//  BLANK_LZ  1  1 = blank leading zeros (hundreds, tens); units never blanked
// PORTS
//  clk        in   1   single clock, rising edge
//  res        in   1   asynchronous, active-low reset
//  din        in   8   binary sample (counter y)
//  din_valid  in   1   din is valid this cycle
//  din_ready  out  1   block can accept din this cycle
//  bcd        out  12  {hundreds,tens,units} of last completed conversion
//  bcd_valid  out  1   one-cycle pulse: bcd just updated
//  seg        out  7   segment pattern {g,f,e,d,c,b,a}, active-high
//  an         out  3   digit enable, one-hot active-high; bit0 = units
// BEHAVIOUR
//  Reset (res=0, async): state=IDLE, bcd=12'h000, bcd_valid=0, scan idx=0,
//   scan div count=0, an=3'b001, seg=7'h3F. Outputs are registered.
//  FSM IDLE -> SHIFT -> DONE -> IDLE. din_ready = (state==IDLE) only.
//  IDLE: on edge with din_valid=1, capture din into shift reg, clear 12-bit
//   scratch BCD, iter=0 -> SHIFT. din_valid=0: stay IDLE.
//  SHIFT: per cycle, add 3 to each scratch nibble >=5, then shift
//   {scratch,shreg} left 1. After 8th shift (iter==7) -> DONE.
//  DONE: bcd<=scratch, bcd_valid=1 for exactly the next cycle, -> IDLE.
//  Latency: capture edge E0, shifts E1..E8, bcd/bcd_valid update at E9.
//   din_ready high again after E9. Throughput: 1 sample / 10 cycles.
//  din/din_valid ignored while busy. No buffering; upstream holds or drops.
//   A free-running counter with din_valid tied 1 is sampled every 10 cycles.
//  Scratch never exceeds 12'h255. Nibbles are always 0..9.
//  Display scan: div counter counts 0..SCAN_DIV-1. On wrap, idx advances
//   0->1->2->0 (never 3). an=1<<idx. seg shows digit idx of bcd (not scratch).
//   The display is unaffected by in-flight conversions.
//  Digit decode: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F
//   blank:00.
//  BLANK_LZ=1: hundreds blank if 0; tens blank if hundreds==0 && tens==0.
//  Reset mid-conversion: abort, bcd=0, no bcd_valid pulse, IDLE on release.
//  Simultaneous scan wrap and bcd update: the new digit shows the new bcd at
//   the same edge.
// TESTING
//  1 Hold res=0 5 cycles, release -> bcd=000, bcd_valid=0, din_ready=1;
//    an cycles 001,010,100 every SCAN_DIV clks; seg 3F,00,00.
//  2 din=255 valid 1 cycle at E0 -> din_ready=0 E0..E9;
//    bcd_valid=1 one cycle after E9; bcd=12'h255; seg 6D,6D,5B.
//  3 din=7 -> bcd=12'h007; units seg=07, tens/hundreds seg=00 (BLANK_LZ=1).
//  4 din=100 -> bcd=12'h100; tens seg=3F (inner zero not blanked),
//    hundreds seg=06.
//  5 din_valid tied 1, din driven by ramping counter -> captures at E0, E10,
//    E20...; each bcd matches the captured din; mid-busy din changes ignored.
//  6 res low at E4 of a conversion of 200 -> bcd=000 immediately,
//    no bcd_valid; after release, next din=200 yields 12'h200.

Source files
------------

// File: rtl/count_bcd_display_if.sv
// Sample handshake into the BCD display block: din is taken on any edge where din_valid && din_ready.
// No buffering on the consumer side, so the upstream must hold the sample or drop it while din_ready is low.
interface count_bcd_display_if;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/count_bcd_display.sv
// Binary-to-BCD (double-dabble) converter driving a 3-digit multiplexed 7-segment display; bcd lands 9 edges after capture.
// din_ready is high only in IDLE, so throughput is one sample per 10 cycles and anything offered while busy is ignored.
module count_bcd_display #(
    parameter int SCAN_DIV = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                clk,
    input  logic                res,
    count_bcd_display_if.slave  in_if,
    output logic [11:0]         bcd,
    output logic                bcd_valid,
    output logic [6:0]          seg,
    output logic [2:0]          an
);
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [7:0]         shreg_q, shreg_d;
    logic [11:0]        scratch_q, scratch_d;
    logic [2:0]         iter_q, iter_d;
    logic [11:0]        bcd_q, bcd_d;
    logic               bcd_valid_q, bcd_valid_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic [1:0]         idx_q, idx_d;
    logic [6:0]         seg_q, seg_d;
    logic [2:0]         an_q, an_d;

    logic [11:0]        adj;
    logic [3:0]         digit;
    logic               blank;

    function automatic logic [11:0] add3(input logic [11:0] s);
        logic [11:0] r;
        r = s;
        for (int i = 0; i < 3; i++) begin
            if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        scratch_d   = scratch_q;
        iter_d      = iter_q;
        bcd_d       = bcd_q;
        bcd_valid_d = 1'b0;
        adj         = add3(scratch_q);

        case (state_q)
            IDLE: begin
                if (in_if.din_valid) begin
                    shreg_d   = in_if.din;
                    scratch_d = 12'h000;
                    iter_d    = 3'd0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = {adj[10:0], shreg_q[7]};
                shreg_d   = {shreg_q[6:0], 1'b0};
                iter_d    = iter_q + 3'd1;
                if (iter_q == 3'd7) state_d = DONE;
            end
            DONE: begin
                bcd_d       = scratch_q;
                bcd_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Scan position and digit content both use next-state values so a wrap
        // coinciding with a bcd update shows the new value immediately.
        if (div_q == CNT_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end else begin
            div_d = div_q + CNT_W'(1);
            idx_d = idx_q;
        end
        an_d = 3'b001 << idx_d;

        digit = 4'd0;
        blank = 1'b0;
        case (idx_d)
            2'd0: digit = bcd_d[3:0];
            2'd1: begin
                digit = bcd_d[7:4];
                blank = BLANK_LZ && (bcd_d[11:4] == 8'h00);
            end
            default: begin
                digit = bcd_d[11:8];
                blank = BLANK_LZ && (bcd_d[11:8] == 4'h0);
            end
        endcase
        seg_d = blank ? 7'h00 : decode(digit);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q     <= IDLE;
            shreg_q     <= 8'h00;
            scratch_q   <= 12'h000;
            iter_q      <= 3'd0;
            bcd_q       <= 12'h000;
            bcd_valid_q <= 1'b0;
            div_q       <= '0;
            idx_q       <= 2'd0;
            seg_q       <= 7'h3F;
            an_q        <= 3'b001;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            scratch_q   <= scratch_d;
            iter_q      <= iter_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
            div_q       <= div_d;
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign in_if.din_ready = (state_q == IDLE);
    assign bcd             = bcd_q;
    assign bcd_valid       = bcd_valid_q;
    assign seg             = seg_q;
    assign an              = an_q;
endmodule

// File: tb/tb_count_bcd_display.sv
// Bench for count_bcd_display: random and directed samples checked against an arithmetic decimal-digit model.
module tb_count_bcd_display;
    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic [6:0]  seg;
    logic [2:0]  an;

    int pass_cnt = 0;
    int total    = 0;

    logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    count_bcd_display_if u_if ();

    count_bcd_display #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut (
        .clk       (clk),
        .res       (res),
        .in_if     (u_if),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .seg       (seg),
        .an        (an)
    );

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Expected segments for display position idx when the held value is v.
    function automatic logic [6:0] seg_model(input int v, input int idx);
        int d;
        bit blk;
        blk = 1'b0;
        if (idx == 0)      d = v % 10;
        else if (idx == 1) begin d = (v / 10) % 10; blk = (v < 10);  end
        else               begin d = v / 100;       blk = (v < 100); end
        return blk ? 7'h00 : seg_tab[d];
    endfunction

    task automatic test_reset();
        res = 1'b0;
        u_if.din = 8'h00;
        u_if.din_valid = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (bcd !== 12'h000 || bcd_valid !== 1'b0 || u_if.din_ready !== 1'b1 ||
            an !== 3'b001 || seg !== 7'h3F) begin
            $display("FAIL reset_state: bcd=%h vld=%b rdy=%b an=%b seg=%h, want 000 0 1 001 3f",
                     bcd, bcd_valid, u_if.din_ready, an, seg);
        end else pass_cnt++;
        res = 1'b1;
        for (int n = 0; n < 3 * SCAN_DIV + 2; n++) begin
            int k;
            k = (n / SCAN_DIV) % 3;
            total++;
            if (an !== 3'(1 << k) || seg !== seg_model(0, k))
                $display("FAIL reset_scan[%0d]: an=%b seg=%h, want an=%b seg=%h",
                         n, an, seg, 3'(1 << k), seg_model(0, k));
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    // Offers one sample and checks handshake timing and the converted result.
    task automatic test_conversion(input int v);
        int bad;
        total++;
        if (u_if.din_ready !== 1'b1) $display("FAIL conv_ready_%0d: din_ready=%b, want 1", v, u_if.din_ready);
        else pass_cnt++;
        u_if.din = 8'(v);
        u_if.din_valid = 1'b1;
        @(negedge clk);
        bad = 0;
        for (int k = 0; k < 9; k++) begin
            u_if.din = 8'($urandom);
            u_if.din_valid = 1'($urandom);
            if (u_if.din_ready !== 1'b0 || bcd_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        u_if.din_valid = 1'b0;
        total++;
        if (bad !== 0) $display("FAIL conv_busy_%0d: %0d busy cycles wrong, want 0", v, bad);
        else pass_cnt++;
        total++;
        if (bcd_valid !== 1'b1 || bcd !== to_bcd(v) || u_if.din_ready !== 1'b1)
            $display("FAIL conv_result_%0d: vld=%b bcd=%h rdy=%b, want 1 %h 1",
                     v, bcd_valid, bcd, u_if.din_ready, to_bcd(v));
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (bcd_valid !== 1'b0) $display("FAIL conv_pulse_%0d: bcd_valid=%b, want 0", v, bcd_valid);
        else pass_cnt++;
    endtask

    task automatic test_display(input int v);
        for (int k = 0; k < 3; k++) begin
            int n;
            n = 0;
            while (an !== 3'(1 << k) && n < 4 * SCAN_DIV) begin
                @(negedge clk);
                n++;
            end
            total++;
            if (an !== 3'(1 << k))
                $display("FAIL disp_timeout_%0d_%0d: an=%b, want %b", v, k, an, 3'(1 << k));
            else if (seg !== seg_model(v, k))
                $display("FAIL disp_seg_%0d_%0d: seg=%h, want %h", v, k, seg, seg_model(v, k));
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            int v;
            v = int'($urandom_range(0, 255));
            test_conversion(v);
            test_display(v);
        end
    endtask

    // din_valid held high with a ramping din: captures at edges 0,10,20,...
    task automatic test_back_to_back(input int s);
        for (int j = 0; j < 40; j++) begin
            bit exp_v;
            u_if.din = 8'(s + j);
            u_if.din_valid = 1'b1;
            @(negedge clk);
            exp_v = (j % 10 == 9);
            total++;
            if (bcd_valid !== exp_v || u_if.din_ready !== exp_v ||
                (exp_v && bcd !== to_bcd((s + j - 9) % 256)))
                $display("FAIL stream[%0d]: vld=%b rdy=%b bcd=%h, want vld=%b rdy=%b bcd=%h",
                         j, bcd_valid, u_if.din_ready, bcd, exp_v, exp_v, to_bcd((s + j - 9) % 256));
            else pass_cnt++;
        end
        u_if.din_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int bad;
        u_if.din = 8'd200;
        u_if.din_valid = 1'b1;
        @(negedge clk);
        u_if.din_valid = 1'b0;
        repeat (3) @(negedge clk);
        res = 1'b0;
        #1;
        total++;
        if (bcd !== 12'h000 || bcd_valid !== 1'b0 || an !== 3'b001 || seg !== 7'h3F)
            $display("FAIL midreset_state: bcd=%h vld=%b an=%b seg=%h, want 000 0 001 3f",
                     bcd, bcd_valid, an, seg);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        res = 1'b1;
        bad = 0;
        for (int n = 0; n < 12; n++) begin
            if (bcd_valid !== 1'b0 || bcd !== 12'h000) bad++;
            @(negedge clk);
        end
        total++;
        if (bad !== 0) $display("FAIL midreset_quiet: %0d cycles with pulse or nonzero bcd, want 0", bad);
        else pass_cnt++;
        test_conversion(200);
        test_display(200);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_conversion(255);
        test_display(255);
        test_conversion(7);
        test_display(7);
        test_conversion(100);
        test_display(100);
        test_conversion(0);
        test_display(0);
        test_random();
        test_back_to_back(37);
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
